// File: rtl/nzcv_flag_unit_if.sv
// Bus between an ALU and the NZCV flag unit: result/operand inputs, condition
// query and the registered flag, condition and overflow-debug outputs.
interface nzcv_flag_unit_if #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             set_flags;
    logic             op_sub;
    logic             op_logic;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic [3:0]       cond;
    logic             ovf_clear;

    logic             Zero;
    logic             Neg;
    logic             C_out;
    logic             OverFlow;
    logic             cond_true;
    logic             out_valid;
    logic             ovf_sticky;
    logic [CNT_W-1:0] ovf_count;

    modport master (
        output in_valid, set_flags, op_sub, op_logic, a, b, result, carry_out, cond, ovf_clear,
        input  Zero, Neg, C_out, OverFlow, cond_true, out_valid, ovf_sticky, ovf_count
    );

    modport slave (
        input  in_valid, set_flags, op_sub, op_logic, a, b, result, carry_out, cond, ovf_clear,
        output Zero, Neg, C_out, OverFlow, cond_true, out_valid, ovf_sticky, ovf_count
    );
endinterface

// File: rtl/nzcv_flag_unit.sv
// Architectural NZCV flag register with next-flag computation, LEGv8 B.cond
// evaluation against the stored flags and a saturating overflow event counter.
module nzcv_flag_unit #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    nzcv_flag_unit_if.slave     bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             next_n;
    logic             next_z;
    logic             next_c;
    logic             next_v;
    logic             a_msb;
    logic             b_msb;
    logic             r_msb;
    logic             write_en;
    logic             ovf_event;

    logic             n_q;
    logic             z_q;
    logic             c_q;
    logic             v_q;
    logic             valid_q;
    logic             sticky_q;
    logic [CNT_W-1:0] count_q;
    logic             cond_raw;
    logic             cond_res;

    // Sub overflow uses the un-inverted b, so the sign test flips relative to add.
    always_comb begin
        a_msb  = bus.a[WIDTH-1];
        b_msb  = bus.b[WIDTH-1];
        r_msb  = bus.result[WIDTH-1];
        next_n = r_msb;
        next_z = (bus.result == '0);
        next_c = bus.carry_out;
        if (bus.op_sub)
            next_v = (a_msb != b_msb) && (r_msb != a_msb);
        else
            next_v = (a_msb == b_msb) && (r_msb != a_msb);
        if (bus.op_logic) begin
            next_c = 1'b0;
            next_v = 1'b0;
        end
    end

    assign write_en  = bus.in_valid & bus.set_flags;
    assign ovf_event = write_en & next_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (write_en) begin
                n_q <= next_n;
                z_q <= next_z;
                c_q <= next_c;
                v_q <= next_v;
            end
        end
    end

    // An event in the same cycle as a clear wins and restarts the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else if (ovf_event) begin
            sticky_q <= 1'b1;
            if (bus.ovf_clear)
                count_q <= CNT_ONE;
            else if (count_q != CNT_MAX)
                count_q <= count_q + CNT_ONE;
        end else if (bus.ovf_clear) begin
            sticky_q <= 1'b0;
            count_q  <= '0;
        end
    end

    // Odd condition codes are the complement of the even code below them.
    always_comb begin
        cond_raw = 1'b1;
        unique case (bus.cond[3:1])
            3'b000: cond_raw = z_q;
            3'b001: cond_raw = c_q;
            3'b010: cond_raw = n_q;
            3'b011: cond_raw = v_q;
            3'b100: cond_raw = c_q & ~z_q;
            3'b101: cond_raw = (n_q == v_q);
            3'b110: cond_raw = ~z_q & (n_q == v_q);
            3'b111: cond_raw = 1'b1;
        endcase
        if (bus.cond[3:1] == 3'b111)
            cond_res = 1'b1;
        else
            cond_res = cond_raw ^ bus.cond[0];
    end

    assign bus.Zero       = z_q;
    assign bus.Neg        = n_q;
    assign bus.C_out      = c_q;
    assign bus.OverFlow   = v_q;
    assign bus.out_valid  = valid_q;
    assign bus.ovf_sticky = sticky_q;
    assign bus.ovf_count  = count_q;
    assign bus.cond_true  = cond_res;
endmodule

// File: tb/tb_nzcv_flag_unit.sv
// Randomised self-checking bench for nzcv_flag_unit: a 64-bit instance against
// an arithmetic reference model and an 8-bit instance for counter saturation.
module tb_nzcv_flag_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    localparam logic signed [64:0] SMAX = 65'sd9223372036854775807;
    localparam logic signed [64:0] SMIN = -SMAX - 65'sd1;

    nzcv_flag_unit_if #(.WIDTH(64), .CNT_W(8)) if64 ();
    nzcv_flag_unit_if #(.WIDTH(8),  .CNT_W(2)) if8 ();

    nzcv_flag_unit #(.WIDTH(64), .CNT_W(8)) u64 (.clk(clk), .rst_n(rst_n), .bus(if64));
    nzcv_flag_unit #(.WIDTH(8),  .CNT_W(2)) u8  (.clk(clk), .rst_n(rst_n), .bus(if8));

    always #5 clk = ~clk;

    bit m_n, m_z, m_c, m_v, m_valid, m_sticky;
    int m_cnt;

    task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic bit cond_model(input int c, input bit n, input bit z, input bit cc, input bit v);
        bit r;
        case (c / 2)
            0: r = z;
            1: r = cc;
            2: r = n;
            3: r = v;
            4: r = cc && !z;
            5: r = (n == v);
            6: r = !z && (n == v);
            default: return 1'b1;
        endcase
        return (c % 2 == 1) ? !r : r;
    endfunction

    task automatic model_reset();
        m_n = 0; m_z = 0; m_c = 0; m_v = 0; m_valid = 0; m_sticky = 0; m_cnt = 0;
    endtask

    task automatic check_state(input string tag);
        check_output({tag, ".Z"},   if64.Zero,       m_z);
        check_output({tag, ".N"},   if64.Neg,        m_n);
        check_output({tag, ".C"},   if64.C_out,      m_c);
        check_output({tag, ".V"},   if64.OverFlow,   m_v);
        check_output({tag, ".ov"},  if64.out_valid,  m_valid);
        check_output({tag, ".stk"}, if64.ovf_sticky, m_sticky);
        check_output({tag, ".cnt"}, if64.ovf_count,  m_cnt);
    endtask

    task automatic sweep_conds(input string tag);
        for (int c = 0; c < 16; c++) begin
            if64.cond = 4'(c);
            #1;
            check_output($sformatf("%s.cond%0d", tag, c), if64.cond_true, cond_model(c, m_n, m_z, m_c, m_v));
        end
    endtask

    // One ALU cycle on the 64-bit instance, then model update and full check.
    task automatic apply_stimulus(input string tag, input bit valid, input bit setf, input bit sub,
                                  input bit lg, input logic [63:0] a, input logic [63:0] b,
                                  input logic [63:0] res, input bit co, input bit clr);
        logic signed [64:0] s;
        bit v;
        @(negedge clk);
        if64.in_valid  = valid;
        if64.ovf_clear = clr;
        if (valid) begin
            if64.set_flags = setf; if64.op_sub = sub; if64.op_logic = lg;
            if64.a = a; if64.b = b; if64.result = res; if64.carry_out = co;
        end else begin
            if64.set_flags = 1'bx; if64.op_sub = 1'bx; if64.op_logic = 1'bx;
            if64.a = 'x; if64.b = 'x; if64.result = 'x; if64.carry_out = 1'bx;
        end
        s = sub ? ($signed({a[63], a}) - $signed({b[63], b})) : ($signed({a[63], a}) + $signed({b[63], b}));
        v = !lg && (s > SMAX || s < SMIN);
        @(posedge clk);
        #1;
        m_valid = valid;
        if (valid && setf) begin
            m_n = res[63];
            m_z = (res == 64'd0);
            m_c = lg ? 1'b0 : co;
            m_v = v;
        end
        if (valid && setf && v) begin
            m_sticky = 1;
            m_cnt = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
        end else if (clr) begin
            m_sticky = 0;
            m_cnt = 0;
        end
        if64.in_valid = 1'b0;
        if64.ovf_clear = 1'b0;
        check_state(tag);
    endtask

    task automatic random_op(input int idx);
        logic [63:0] a, b, res;
        bit valid, setf, sub, lg, co, clr;
        int pick;
        valid = ($urandom_range(0, 9) < 8);
        setf  = ($urandom_range(0, 9) < 5);
        sub   = $urandom_range(0, 1);
        lg    = ($urandom_range(0, 4) == 0);
        clr   = ($urandom_range(0, 9) == 0);
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        pick = $urandom_range(0, 5);
        if (pick == 0) a = 64'h7FFF_FFFF_FFFF_FFFF;
        if (pick == 1) a = 64'h8000_0000_0000_0000;
        if (pick == 2) b = a;
        if (pick == 3) b = 64'd1;
        if (lg) begin
            res = a & b;
            co  = $urandom_range(0, 1);
        end else if (sub) begin
            res = a - b;
            co  = (a >= b);
        end else begin
            res = a + b;
            co  = ((65'(a) + 65'(b)) >> 64) != 0;
        end
        apply_stimulus($sformatf("rnd%0d", idx), valid, setf, sub, lg, a, b, res, co, clr);
        if (idx % 8 == 0) sweep_conds($sformatf("rnd%0d", idx));
    endtask

    task automatic drive8(input bit clr);
        @(negedge clk);
        if8.in_valid = 1; if8.set_flags = 1; if8.op_sub = 0; if8.op_logic = 0;
        if8.a = 8'h7F; if8.b = 8'h01; if8.result = 8'h80; if8.carry_out = 0; if8.ovf_clear = clr;
        @(posedge clk);
        #1;
        if8.in_valid = 0; if8.ovf_clear = 0;
    endtask

    initial begin
        if64.in_valid = 0; if64.set_flags = 0; if64.op_sub = 0; if64.op_logic = 0;
        if64.a = '0; if64.b = '0; if64.result = '0; if64.carry_out = 0;
        if64.cond = 4'h0; if64.ovf_clear = 0;
        if8.in_valid = 0; if8.set_flags = 0; if8.op_sub = 0; if8.op_logic = 0;
        if8.a = '0; if8.b = '0; if8.result = '0; if8.carry_out = 0;
        if8.cond = 4'h0; if8.ovf_clear = 0;
        model_reset();

        #12;
        check_state("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_state("idle");
        if64.cond = 4'b0001; #1;
        check_output("idle.NE", if64.cond_true, 1'b1);
        if64.cond = 4'b0000; #1;
        check_output("idle.EQ", if64.cond_true, 1'b0);

        apply_stimulus("adds_ovf", 1, 1, 0, 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 0, 0);
        check_output("adds_ovf.V", if64.OverFlow, 1'b1);
        check_output("adds_ovf.cnt", if64.ovf_count, 64'd1);
        if64.cond = 4'b0110; #1;
        check_output("adds_ovf.VS", if64.cond_true, 1'b1);
        sweep_conds("adds_ovf");

        apply_stimulus("subs_eq", 1, 1, 1, 0, 64'd5, 64'd5, 64'd0, 1, 0);
        check_output("subs_eq.Z", if64.Zero, 1'b1);
        if64.cond = 4'b1100; #1;
        check_output("subs_eq.GT", if64.cond_true, 1'b0);
        sweep_conds("subs_eq");
        apply_stimulus("add_noset", 1, 0, 0, 0, 64'd1, 64'd2, 64'd3, 0, 0);
        check_output("add_noset.Z", if64.Zero, 1'b1);
        check_output("add_noset.C", if64.C_out, 1'b1);

        apply_stimulus("subs_ovf", 1, 1, 1, 0, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1, 0);
        if64.cond = 4'b1011; #1;
        check_output("subs_ovf.LT", if64.cond_true, 1'b1);
        sweep_conds("subs_ovf");
        apply_stimulus("ands_zero", 1, 1, 0, 1, 64'hF0, 64'h0F, 64'd0, 1, 0);
        check_output("ands_zero.C", if64.C_out, 1'b0);
        sweep_conds("ands_zero");

        for (int i = 0; i < 300; i++) random_op(i);

        drive8(0);
        check_output("w8.cnt1", if8.ovf_count, 64'd1);
        check_output("w8.V", if8.OverFlow, 1'b1);
        check_output("w8.N", if8.Neg, 1'b1);
        drive8(0);
        check_output("w8.cnt2", if8.ovf_count, 64'd2);
        drive8(0);
        check_output("w8.cnt3", if8.ovf_count, 64'd3);
        drive8(0);
        check_output("w8.sat", if8.ovf_count, 64'd3);
        drive8(1);
        check_output("w8.clr_evt.cnt", if8.ovf_count, 64'd1);
        check_output("w8.clr_evt.stk", if8.ovf_sticky, 1'b1);
        @(negedge clk);
        if8.ovf_clear = 1;
        @(posedge clk);
        #1;
        if8.ovf_clear = 0;
        check_output("w8.clr.cnt", if8.ovf_count, 64'd0);
        check_output("w8.clr.stk", if8.ovf_sticky, 1'b0);

        apply_stimulus("pre_rst", 1, 1, 1, 0, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0);
        @(negedge clk);
        if64.in_valid = 1; if64.set_flags = 1; if64.op_sub = 0; if64.op_logic = 0;
        if64.a = 64'h7FFF_FFFF_FFFF_FFFF; if64.b = 64'd1;
        if64.result = 64'h8000_0000_0000_0000; if64.carry_out = 0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state("midrst");
        @(posedge clk);
        #1;
        check_state("rst_held");
        check_output("rst_held.w8cnt", if8.ovf_count, 64'd0);
        @(negedge clk);
        if64.in_valid = 0;
        rst_n = 1'b1;
        apply_stimulus("post_rst", 1, 1, 0, 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 0, 0);
        sweep_conds("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nzcv_flag_unit.md
Name: nzcv_flag_unit

Overview:
- Parametrised successor to the combinational zero/negative/carry/overflow detector.
- Computes N, Z, C and V for an ALU result of any width, with correct two's-complement overflow for add and subtract.
- Holds the flags in an architectural NZCV register written only by flag-setting instructions (ADDS/SUBS/ANDS).
- Evaluates LEGv8 B.cond conditions against the stored flags and keeps a saturating overflow event counter for debug.

Parameters:
- WIDTH, 64, operand/result width in bits (>= 2).
- CNT_W, 8, width of the saturating overflow event counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  ALU result valid this cycle.
- set_flags  input  1  instruction updates NZCV; ignored unless in_valid.
- op_sub  input  1  1 = subtract (result = a + ~b + 1), 0 = add/logical.
- op_logic  input  1  1 = logical op; C and V are forced to 0.
- a  input  WIDTH  ALU operand A.
- b  input  WIDTH  ALU operand B, as presented to the instruction before inversion.
- result  input  WIDTH  ALU result.
- carry_out  input  1  adder carry out of bit WIDTH-1.
- cond  input  4  B.cond condition code.
- ovf_clear  input  1  clears ovf_sticky and ovf_count.
- Zero  output  1  registered Z flag.
- Neg  output  1  registered N flag.
- C_out  output  1  registered C flag.
- OverFlow  output  1  registered V flag.
- cond_true  output  1  combinational condition result from the registered flags.
- out_valid  output  1  in_valid delayed one cycle.
- ovf_sticky  output  1  set by any flag-setting op that produces V=1.
- ovf_count  output  CNT_W  saturating count of V=1 flag-setting ops.

Behaviour:
- Reset (rst_n low, asynchronous): Zero, Neg, C_out, OverFlow, out_valid, ovf_sticky and ovf_count all 0. cond_true then follows the all-zero flags.
- Next-flag computation (combinational):
  - N = result[WIDTH-1].
  - Z = (result == 0), compared over the full WIDTH.
  - C = carry_out.
  - V for add: a[W-1]==b[W-1] and result[W-1]!=a[W-1].
  - V for sub: a[W-1]!=b[W-1] and result[W-1]!=a[W-1].
  - If op_logic: C = 0, V = 0.
- Flag register write: on the rising edge when in_valid & set_flags, all four flags load together. Otherwise they hold.
- Latency: flags and out_valid are visible 1 cycle after the input. There is no bypass. A B.cond in the cycle immediately after a flag write sees the new flags; in the same cycle it sees the old flags.
- cond_true decode (ARMv8 encoding):
  - 0000 EQ: Z. 0001 NE: !Z.
  - 0010 HS: C. 0011 LO: !C.
  - 0100 MI: N. 0101 PL: !N.
  - 0110 VS: V. 0111 VC: !V.
  - 1000 HI: C&!Z. 1001 LS: !(C&!Z).
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: !Z&(N==V). 1101 LE: the complement of GT.
  - 1110 and 1111: 1.
- Overflow tracking:
  - An event is in_valid & set_flags & next-V.
  - Each event sets ovf_sticky and increments ovf_count, which saturates at 2^CNT_W-1 (no wrap).
  - ovf_clear zeroes both on the next edge. When a clear and an event occur in the same cycle, the event wins: sticky = 1, count = 1.
- Reset mid-operation discards any pending update; the first valid input after rst_n rises is processed normally.
- All outputs are X-free after reset regardless of input X on non-valid cycles. Inputs are ignored when in_valid = 0.

Test Plan:
- Reset, then idle: Zero=Neg=C_out=OverFlow=0, cond=0001 -> cond_true=1, cond=0000 -> cond_true=0, ovf_count=0.
- ADDS with W=64, a=0x7FFF_FFFF_FFFF_FFFF, b=1, result=0x8000_0000_0000_0000, carry_out=0 -> next cycle N=1, Z=0, C=0, V=1, ovf_sticky=1, ovf_count=1, cond=0110 VS -> cond_true=1.
- SUBS a=5, b=5, result=0, carry_out=1 -> Z=1, C=1, N=0, V=0. EQ=1, HS=1, GT=0, LE=1. A following non-setting add with result=3 leaves the flags unchanged.
- SUBS a=0x8000_0000_0000_0000, b=1, result=0x7FFF_FFFF_FFFF_FFFF, carry_out=1 -> V=1, N=0, GE=0, LT=1. ANDS with result=0 -> Z=1, C=0, V=0.
- WIDTH=8, CNT_W=2 instance: four overflowing ADDS (a=0x7F, b=0x01) -> ovf_count saturates at 3. ovf_clear asserted together with a fifth overflowing ADDS -> count=1, sticky=1.
- rst_n pulsed low asynchronously mid-cycle while in_valid & set_flags are asserted -> all outputs 0 immediately, no flag update on the following edge while reset is held.
